// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank driver.
package jk_pkg;

  // Driver sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // {J,K} excitation codes
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  // Width of the attempts counter
  localparam int ATT_W = 4;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: the {J,K} that moves Q to T on the next edge.
module jk_excite
  import jk_pkg::*;
#(
  parameter int USE_TOGGLE = 1
) (
  input  logic       q,
  input  logic       t,
  output logic [1:0] jk
);

  // Hold when already there, else toggle or force toward the target
  always_comb begin
    jk = HOLD;
    if (q != t) jk = (USE_TOGGLE != 0) ? TGL : (t ? SET : RST);
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a requested value, verifies Q and
// retries a bounded number of times before reporting an error.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter int USE_TOGGLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       attempts
);

  state_t                 state;
  logic [WIDTH-1:0]       target;
  logic [WIDTH-1:0]       tgt_sel;
  logic [WIDTH-1:0][1:0]  exc;
  logic [WIDTH-1:0]       exc_j, exc_k;

  // The excitation is computed one cycle ahead (on the edge entering DRIVE)
  // so jk_j/jk_k leave the block straight from flops. The bank is held in
  // IDLE and CHECK, so q_fb then equals q_fb during the DRIVE cycle.
  assign tgt_sel = (state == IDLE) ? req_target : target;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jk_excite #(.USE_TOGGLE(USE_TOGGLE)) u_exc (
      .q  (q_fb[i]),
      .t  (tgt_sel[i]),
      .jk (exc[i])
    );
    assign exc_j[i] = exc[i][1];
    assign exc_k[i] = exc[i][0];
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer with registered JK drive and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target   <= '0;
      attempts <= '0;
      jk_j     <= '0;
      jk_k     <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      jk_j  <= '0;
      jk_k  <= '0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target   <= req_target;
            attempts <= '0;
            jk_j     <= exc_j;
            jk_k     <= exc_k;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          attempts <= (attempts == '1) ? attempts : attempts + ATT_W'(1);
          state    <= CHECK;
        end
        CHECK: begin
          if (q_fb == target) begin
            done  <= 1'b1;
            state <= REPORT;
          end else if (32'(attempts) <= MAX_RETRY) begin
            jk_j  <= exc_j;
            jk_k  <= exc_k;
            state <= DRIVE;
          end else begin
            error <= 1'b1;
            state <= REPORT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (toggle/3 retries, set-reset/0 retries)
// each driving a behavioural JK bank with optional stuck-at-0 bits.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid [2];
  logic [7:0] req_target[2];
  logic       req_ready [2];
  logic [7:0] q_fb      [2];
  logic [7:0] jk_j      [2];
  logic [7:0] jk_k      [2];
  logic       busy      [2];
  logic       done      [2];
  logic       error     [2];
  logic [3:0] attempts  [2];
  logic       ld        [2];
  logic [7:0] ld_val    [2];
  logic [7:0] stuck     [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .USE_TOGGLE(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_target(req_target[0]), .q_fb(q_fb[0]), .jk_j(jk_j[0]), .jk_k(jk_k[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .attempts(attempts[0]));

  jk_bank_driver #(.WIDTH(8), .MAX_RETRY(0), .USE_TOGGLE(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_target(req_target[1]), .q_fb(q_fb[1]), .jk_j(jk_j[1]), .jk_k(jk_k[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .attempts(attempts[1]));

  // Ideal JK bank: Q+ = J&~Q | ~K&Q, stuck bits forced to 0
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (ld[d]) q_fb[d] <= ld_val[d] & ~stuck[d];
      else       q_fb[d] <= ((jk_j[d] & ~q_fb[d]) | (~jk_k[d] & q_fb[d])) & ~stuck[d];

  function automatic int mr(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  // Expected behaviour of one request from the rules, not the state machine
  function automatic void model(input int d, input logic [7:0] q0, t, stk,
                                output logic [7:0] ej, ek, output logic ok,
                                output int drives, output logic [7:0] qf);
    logic [7:0] diff;
    diff = q0 ^ t;
    if (d == 0) begin ej = diff; ek = diff; end
    else begin ej = diff & t; ek = diff & ~t; end
    ok     = ((t & ~stk) == t);
    drives = ok ? 1 : mr(d) + 1;
    qf     = t & ~stk;
  endfunction

  task automatic set_q(input int d, input logic [7:0] v);
    @(negedge clk); ld[d] = 1'b1; ld_val[d] = v;
    @(posedge clk); #1; ld[d] = 1'b0;
  endtask

  // One request; k counts rising edges after the accept edge (k=0 is the accept)
  task automatic do_req(input int d, input logic [7:0] tgt,
                        output logic [7:0] fj, fk, output int nz, n_done, n_err,
                        output int done_at, err_at, rdy_at, both, output logic [3:0] att);
    nz = 0; n_done = 0; n_err = 0; done_at = -1; err_at = -1; rdy_at = -1; both = 0;
    att = 'x;
    @(negedge clk); req_valid[d] = 1'b1; req_target[d] = tgt;
    @(posedge clk); #1; req_valid[d] = 1'b0; req_target[d] = 8'($urandom);
    fj = jk_j[d]; fk = jk_k[d];
    for (int k = 0; k < 64; k++) begin
      if (jk_j[d] != 0 || jk_k[d] != 0) nz++;
      if (done[d])  begin n_done++; done_at = k; end
      if (error[d]) begin n_err++;  err_at  = k; end
      if (done[d] && error[d]) both++;
      if (req_ready[d]) begin rdy_at = k; att = attempts[d]; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (req_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready d=%0d got %b want 1", d, req_ready[d]); end
      n_chk++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d=%0d got %b want 0", d, busy[d]); end
      n_chk++; if ({done[d], error[d]} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses d=%0d got %b want 00", d, {done[d], error[d]}); end
      n_chk++; if ({jk_j[d], jk_k[d]} !== 16'h0) begin n_fail++; $display("FAIL reset_jk d=%0d got %h want 0000", d, {jk_j[d], jk_k[d]}); end
      n_chk++; if (attempts[d] !== 4'd0) begin n_fail++; $display("FAIL reset_attempts d=%0d got %0d want 0", d, attempts[d]); end
    end
  endtask

  task automatic test_toggle_a5();
    logic [7:0] fj, fk; int nz, nd, ne, da, ea, ra, bo; logic [3:0] at;
    set_q(0, 8'h00);
    do_req(0, 8'hA5, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if ({fj, fk} !== 16'hA5A5) begin n_fail++; $display("FAIL a5_jk got j=%h k=%h want a5/a5", fj, fk); end
    n_chk++; if (nz !== 1) begin n_fail++; $display("FAIL a5_drives got %0d want 1", nz); end
    n_chk++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL a5_pulses got done=%0d err=%0d want 1/0", nd, ne); end
    n_chk++; if (da !== 2) begin n_fail++; $display("FAIL a5_done_latency got edge %0d want 2 (seen at edge 3)", da); end
    n_chk++; if (ra !== 3) begin n_fail++; $display("FAIL a5_ready_latency got edge %0d want 3 (accept at edge 4)", ra); end
    n_chk++; if (at !== 4'd1) begin n_fail++; $display("FAIL a5_attempts got %0d want 1", at); end
    n_chk++; if (q_fb[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_q got %h want a5", q_fb[0]); end
  endtask

  task automatic test_set_reset();
    logic [7:0] fj, fk; int nz, nd, ne, da, ea, ra, bo; logic [3:0] at;
    set_q(1, 8'hF0);
    do_req(1, 8'h3C, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if (fj !== 8'h0C) begin n_fail++; $display("FAIL sr_j got %h want 0c", fj); end
    n_chk++; if (fk !== 8'hC0) begin n_fail++; $display("FAIL sr_k got %h want c0", fk); end
    n_chk++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL sr_pulses got done=%0d err=%0d want 1/0", nd, ne); end
    n_chk++; if (q_fb[1] !== 8'h3C) begin n_fail++; $display("FAIL sr_q got %h want 3c", q_fb[1]); end
  endtask

  task automatic test_stuck_retry();
    logic [7:0] fj, fk; int nz, nd, ne, da, ea, ra, bo; logic [3:0] at;
    stuck[0] = 8'h01;
    set_q(0, 8'h00);
    do_req(0, 8'h01, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if (nz !== 4) begin n_fail++; $display("FAIL stuck_drives got %0d want 4", nz); end
    n_chk++; if (ne !== 1 || nd !== 0) begin n_fail++; $display("FAIL stuck_pulses got done=%0d err=%0d want 0/1", nd, ne); end
    n_chk++; if (ea !== 8) begin n_fail++; $display("FAIL stuck_err_at got edge %0d want 8", ea); end
    n_chk++; if (at !== 4'd4) begin n_fail++; $display("FAIL stuck_attempts got %0d want 4", at); end
    stuck[0] = 8'h00;
    stuck[1] = 8'h01;
    set_q(1, 8'h00);
    do_req(1, 8'h01, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if (nz !== 1) begin n_fail++; $display("FAIL mr0_drives got %0d want 1", nz); end
    n_chk++; if (ne !== 1 || nd !== 0) begin n_fail++; $display("FAIL mr0_pulses got done=%0d err=%0d want 0/1", nd, ne); end
    n_chk++; if (at !== 4'd1 || ea !== 2) begin n_fail++; $display("FAIL mr0_attempts got %0d at edge %0d want 1 at 2", at, ea); end
    stuck[1] = 8'h00;
  endtask

  task automatic test_equal();
    logic [7:0] fj, fk; int nz, nd, ne, da, ea, ra, bo; logic [3:0] at;
    set_q(0, 8'h5A);
    do_req(0, 8'h5A, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if ({fj, fk} !== 16'h0000) begin n_fail++; $display("FAIL eq_jk got j=%h k=%h want 00/00", fj, fk); end
    n_chk++; if (nd !== 1 || da !== 2) begin n_fail++; $display("FAIL eq_done got %0d at edge %0d want 1 at 2", nd, da); end
    n_chk++; if (at !== 4'd1) begin n_fail++; $display("FAIL eq_attempts got %0d want 1", at); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] fj, fk; int nz, nd, ne, da, ea, ra, bo; logic [3:0] at; int pulses;
    set_q(0, 8'h00);
    @(negedge clk); req_valid[0] = 1'b1; req_target[0] = 8'h81;
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    n_chk++; if (busy[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state got busy=%b ready=%b want 0/1", busy[0], req_ready[0]); end
    n_chk++; if (attempts[0] !== 4'd0) begin n_fail++; $display("FAIL mid_reset_attempts got %0d want 0", attempts[0]); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (done[0] || error[0] || jk_j[0] != 0 || jk_k[0] != 0) pulses++;
      @(posedge clk); #1;
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_reset_pulses got %0d active samples want 0", pulses); end
    @(negedge clk); reset = 1'b0;
    do_req(0, 8'h33, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
    n_chk++; if (nd !== 1 || at !== 4'd1 || q_fb[0] !== 8'h33) begin n_fail++; $display("FAIL mid_reset_recover got done=%0d att=%0d q=%h want 1/1/33", nd, at, q_fb[0]); end
  endtask

  task automatic test_back_to_back();
    int acc_at[$]; logic [7:0] acc_t[$]; logic [7:0] t, fj; logic rdy; int waited;
    set_q(0, 8'h00);
    fj = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      t = 8'($urandom); req_target[0] = t; req_valid[0] = 1'b1; rdy = req_ready[0];
      @(posedge clk);
      if (rdy) begin acc_at.push_back(i); acc_t.push_back(t); end
      #1;
      if (i == 0) fj = jk_j[0];
    end
    @(negedge clk); req_valid[0] = 1'b0;
    waited = 0;
    while (!req_ready[0] && waited < 20) begin @(negedge clk); waited++; end
    n_chk++; if (waited >= 20) begin n_fail++; $display("FAIL b2b_timeout got %0d cycles want <20", waited); end
    n_chk++; if (acc_at.size() !== 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", acc_at.size()); end
    else begin
      n_chk++; if (acc_at[1] !== 4 || acc_at[2] !== 8) begin n_fail++; $display("FAIL b2b_accept_edges got %0d,%0d want 4,8", acc_at[1], acc_at[2]); end
      n_chk++; if (fj !== acc_t[0]) begin n_fail++; $display("FAIL b2b_first_jk got %h want %h", fj, acc_t[0]); end
      n_chk++; if (q_fb[0] !== acc_t[2]) begin n_fail++; $display("FAIL b2b_final_q got %h want %h", q_fb[0], acc_t[2]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] fj, fk, ej, ek, qf, q0, t; int nz, nd, ne, da, ea, ra, bo, dr, d;
    logic [3:0] at; logic ok;
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(0, 1);
      stuck[d] = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      q0 = 8'($urandom) & ~stuck[d];
      t  = 8'($urandom);
      set_q(d, q0);
      model(d, q0, t, stuck[d], ej, ek, ok, dr, qf);
      do_req(d, t, fj, fk, nz, nd, ne, da, ea, ra, bo, at);
      n_chk++; if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL rnd_jk it=%0d got %h/%h want %h/%h", it, fj, fk, ej, ek); end
      n_chk++; if (nd !== (ok ? 1 : 0) || ne !== (ok ? 0 : 1) || bo !== 0) begin n_fail++; $display("FAIL rnd_outcome it=%0d got done=%0d err=%0d both=%0d want ok=%b", it, nd, ne, bo, ok); end
      n_chk++; if (32'(at) !== dr) begin n_fail++; $display("FAIL rnd_attempts it=%0d got %0d want %0d", it, at, dr); end
      n_chk++; if (ra !== 2 * dr + 1) begin n_fail++; $display("FAIL rnd_ready_at it=%0d got %0d want %0d", it, ra, 2 * dr + 1); end
      n_chk++; if (q_fb[d] !== qf) begin n_fail++; $display("FAIL rnd_q it=%0d got %h want %h", it, q_fb[d], qf); end
      stuck[d] = 8'h00;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_target[d] = 8'h00;
      ld[d] = 1'b1; ld_val[d] = 8'h00; stuck[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b0;
    for (int d = 0; d < 2; d++) ld[d] = 1'b0;
    test_toggle_a5();
    test_set_reset();
    test_stuck_retry();
    test_equal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
